id_branch_stage: RTL and testbench
==================================

Name: id_branch_stage

Overview:
- Decode-side partner of the IF stage.
- Captures IF's inst/pc into the IF/ID register, decodes branch/jump/load, computes br_pc, and registers everything into the ID/EX register.
- Drives branch_control and br_pc back to IF.
- Squashes wrong-path instructions on a taken branch and inserts a one-cycle load-use stall.

Parameters:
- PC_W, 11, PC width; word-addressed, wraps mod 2^PC_W.
- INST_W, 32, instruction width.
- CNT_W, 8, width of the saturating event counters.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset (0 = reset).
- inst  in  INST_W  instruction presented by IF this cycle.
- pc  in  PC_W  PC of inst.
- branch_alu  in  1  EX condition result for the instruction in ID/EX (1 = take). EX drives 1 for J.
- branch_control  out  1  ID/EX holds a valid BEQ/BNE/J.
- br_pc  out  PC_W  registered target of the ID/EX instruction.
- stall  out  1  combinational; IF holds pc when 1.
- ex_valid  out  1  ID/EX slot holds a live instruction.
- ex_inst  out  INST_W  ID/EX instruction.
- ex_pc  out  PC_W  ID/EX PC.
- ex_is_load  out  1  ID/EX instruction is LW.
- squash_cnt  out  CNT_W  number of taken-branch squash events, saturating.
- stall_cnt  out  CNT_W  number of stall cycles, saturating.

Behaviour:
- Decode fields:
  - opcode = inst[31:26], rs = [25:21], rt = [20:16], imm = [15:0].
  - Opcodes: LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010, R 000000.
  - Any other opcode decodes as non-branch, non-load.
- Target computation:
  - BEQ/BNE: br_pc = id_pc + 1 + imm[PC_W-1:0], truncated mod 2^PC_W. Example: pc 0x7FF, imm 0 -> 0x000.
  - J: br_pc = inst[PC_W-1:0].
  - All other opcodes: br_pc = id_pc + 1.
- Reset (async, reset=0):
  - IF/ID and ID/EX registers, both valid bits, br_pc, and both counters go to 0.
  - Hence branch_control=0, ex_valid=0, stall=0.
  - Reset asserted mid-operation discards all in-flight instructions immediately.
- First capture: the first rising edge with reset=1 captures IF's inst/pc into IF/ID with id_valid=1.
- taken = ex_valid & branch_control & branch_alu, sampled at the edge.
- hazard (drives stall combinationally) = id_valid & ex_valid & ex_is_load & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
- Edge actions, in priority order:
  1. taken: IF/ID captures inst/pc with id_valid=0, because IF's current output is wrong-path and IF loads br_pc on this same edge. ID/EX loads a bubble (ex_valid=0). squash_cnt++.
  2. hazard: IF/ID holds its contents and valid bit. ID/EX loads a bubble. stall_cnt++.
  3. else: IF/ID <= {inst, pc, valid=1}; ID/EX <= decoded IF/ID contents with ex_valid=id_valid.
- taken and hazard are mutually exclusive: ID/EX cannot be both a branch and a load. The priority order stands regardless.
- A stall never lasts more than one cycle: the inserted bubble clears hazard on the next cycle.
- Bubbles never assert branch_control, ex_is_load, or hazard. ex_inst/ex_pc may hold stale data while ex_valid=0.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Latency: an instruction presented by IF at edge N appears in ID/EX after edge N+1 when no stall occurs.
- branch_control rises in the cycle after the branch enters ID/EX; IF redirects at the following edge if taken.

Test Plan:
- Reset hold then release; IF supplies R-type at pc 0,1,2 -> ex_valid=0 for first cycle; ex_pc=0 after 2nd edge; branch_control=0; counters 0.
- BEQ at pc 5, imm 3, branch_alu=1 -> br_pc=9, branch_control=1; next edge ex_valid=0, IF/ID valid=0; squash_cnt=1.
- BNE at pc 5, imm 3, branch_alu=0 -> br_pc=9 driven but no squash; instruction at pc 6 proceeds normally; squash_cnt=0.
- LW rt=4 followed by ADD rs=4 -> stall=1 one cycle; ADD held in IF/ID; bubble in ID/EX; stall_cnt=1. LW with rt=0 -> no stall.
- J inst[10:0]=0x123 at pc 0x7FF, plus BEQ at 0x7FF imm 0 -> br_pc=0x123 and 0x000 respectively (wrap).
- 300 taken branches -> squash_cnt saturates at 255. Reset pulsed low mid-stall -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_branch_stage.sv
// Decode stage: IF/ID and ID/EX pipeline registers, branch/jump/load decode,
// branch target generation, taken-branch squash and one-cycle load-use stall.
module id_branch_stage #(
  parameter int PC_W   = 11,
  parameter int INST_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INST_W-1:0] inst,
  input  logic [PC_W-1:0]   pc,
  input  logic              branch_alu,
  output logic              branch_control,
  output logic [PC_W-1:0]   br_pc,
  output logic              stall,
  output logic              ex_valid,
  output logic [INST_W-1:0] ex_inst,
  output logic [PC_W-1:0]   ex_pc,
  output logic              ex_is_load,
  output logic [CNT_W-1:0]  squash_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  logic [INST_W-1:0] id_inst_r;
  logic [PC_W-1:0]   id_pc_r;
  logic              id_valid_r;

  logic [INST_W-1:0] ex_inst_r;
  logic [PC_W-1:0]   ex_pc_r;
  logic              ex_valid_r;
  logic              ex_is_load_r;
  logic              branch_control_r;
  logic [PC_W-1:0]   br_pc_r;
  logic [CNT_W-1:0]  squash_cnt_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  logic [5:0]        id_op_s;
  logic [4:0]        id_rs_s;
  logic [4:0]        id_rt_s;
  logic [4:0]        ex_rt_s;
  logic              id_is_load_s;
  logic              id_is_br_s;
  logic [PC_W-1:0]   id_target_s;
  logic              taken_s;
  logic              hazard_s;

  assign id_op_s = id_inst_r[31:26];
  assign id_rs_s = id_inst_r[25:21];
  assign id_rt_s = id_inst_r[20:16];
  assign ex_rt_s = ex_inst_r[20:16];

  // Decode the IF/ID instruction and form its target; low PC_W bits serve as both imm and jump field
  always_comb begin
    id_is_load_s = 1'b0;
    id_is_br_s   = 1'b0;
    id_target_s  = id_pc_r + PC_W'(1);
    case (id_op_s)
      OP_LW: begin
        id_is_load_s = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        id_is_br_s  = 1'b1;
        id_target_s = id_pc_r + PC_W'(1) + id_inst_r[PC_W-1:0];
      end
      OP_J: begin
        id_is_br_s  = 1'b1;
        id_target_s = id_inst_r[PC_W-1:0];
      end
      default: begin
        id_is_load_s = 1'b0;
        id_is_br_s   = 1'b0;
      end
    endcase
  end

  // Redirect and load-use detection; bubbles carry cleared flags so they never trigger either
  always_comb begin
    taken_s  = ex_valid_r & branch_control_r & branch_alu;
    hazard_s = id_valid_r & ex_valid_r & ex_is_load_r & (ex_rt_s != 5'd0) &
               ((ex_rt_s == id_rs_s) | (ex_rt_s == id_rt_s));
  end

  // IF/ID register: wrong-path capture on taken, hold on hazard, else advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_inst_r  <= {INST_W{1'b0}};
      id_pc_r    <= {PC_W{1'b0}};
      id_valid_r <= 1'b0;
    end else if (taken_s) begin
      id_inst_r  <= inst;
      id_pc_r    <= pc;
      id_valid_r <= 1'b0;
    end else if (!hazard_s) begin
      id_inst_r  <= inst;
      id_pc_r    <= pc;
      id_valid_r <= 1'b1;
    end
  end

  // ID/EX register: bubble on taken or hazard, stale payload kept under a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_inst_r        <= {INST_W{1'b0}};
      ex_pc_r          <= {PC_W{1'b0}};
      ex_valid_r       <= 1'b0;
      ex_is_load_r     <= 1'b0;
      branch_control_r <= 1'b0;
      br_pc_r          <= {PC_W{1'b0}};
    end else if (taken_s || hazard_s) begin
      ex_valid_r       <= 1'b0;
      ex_is_load_r     <= 1'b0;
      branch_control_r <= 1'b0;
    end else begin
      ex_inst_r        <= id_inst_r;
      ex_pc_r          <= id_pc_r;
      ex_valid_r       <= id_valid_r;
      ex_is_load_r     <= id_valid_r & id_is_load_s;
      branch_control_r <= id_valid_r & id_is_br_s;
      br_pc_r          <= id_target_s;
    end
  end

  // Saturating event counters; taken has priority so a cycle counts at most one event
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      squash_cnt_r <= {CNT_W{1'b0}};
      stall_cnt_r  <= {CNT_W{1'b0}};
    end else if (taken_s) begin
      squash_cnt_r <= sat_inc(squash_cnt_r);
    end else if (hazard_s) begin
      stall_cnt_r <= sat_inc(stall_cnt_r);
    end
  end

  assign branch_control = branch_control_r;
  assign br_pc          = br_pc_r;
  assign stall          = hazard_s;
  assign ex_valid       = ex_valid_r;
  assign ex_inst        = ex_inst_r;
  assign ex_pc          = ex_pc_r;
  assign ex_is_load     = ex_is_load_r;
  assign squash_cnt     = squash_cnt_r;
  assign stall_cnt      = stall_cnt_r;

endmodule

// File: tb/tb_id_branch_stage.sv
// Directed bench for id_branch_stage: pipeline latency, squash, load-use stall,
// target wrap, counter saturation and asynchronous reset.
module tb_id_branch_stage;
  localparam int PC_W = 11;
  localparam int INST_W = 32;
  localparam int CNT_W = 8;

  logic              clk;
  logic              reset;
  logic [INST_W-1:0] inst;
  logic [PC_W-1:0]   pc;
  logic              branch_alu;
  logic              branch_control;
  logic [PC_W-1:0]   br_pc;
  logic              stall;
  logic              ex_valid;
  logic [INST_W-1:0] ex_inst;
  logic [PC_W-1:0]   ex_pc;
  logic              ex_is_load;
  logic [CNT_W-1:0]  squash_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  int n_cmp;
  int n_err;

  id_branch_stage #(.PC_W(PC_W), .INST_W(INST_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .inst(inst), .pc(pc), .branch_alu(branch_alu),
    .branch_control(branch_control), .br_pc(br_pc), .stall(stall),
    .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc), .ex_is_load(ex_is_load),
    .squash_cnt(squash_cnt), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    mk = {op, rs, rt, imm};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] i, input logic [PC_W-1:0] p);
    inst = i;
    pc   = p;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    branch_alu = 1'b0;
    present(mk(6'b000000, 5'd1, 5'd2, 16'h0020), 11'd0);

    // reset hold
    tick(); tick();
    check_eq("rst_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("rst_bc", 32'(branch_control), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    reset = 1'b1;

    // R-type stream at pc 0,1,2
    tick();
    check_eq("first_ex_valid", 32'(ex_valid), 32'd0);
    present(mk(6'b000000, 5'd1, 5'd2, 16'h0020), 11'd1);
    tick();
    check_eq("r_ex_valid", 32'(ex_valid), 32'd1);
    check_eq("r_ex_pc", 32'(ex_pc), 32'd0);
    check_eq("r_bc", 32'(branch_control), 32'd0);
    check_eq("r_br_pc", 32'(br_pc), 32'd1);
    present(mk(6'b000000, 5'd1, 5'd2, 16'h0020), 11'd2);
    tick();
    check_eq("r_ex_pc2", 32'(ex_pc), 32'd1);
    check_eq("r_squash0", 32'(squash_cnt), 32'd0);
    check_eq("r_stall0", 32'(stall_cnt), 32'd0);

    // taken BEQ at pc 5 imm 3
    branch_alu = 1'b1;
    present(mk(6'b000100, 5'd1, 5'd2, 16'd3), 11'd5);
    tick();
    present(mk(6'b000000, 5'd0, 5'd0, 16'd0), 11'd6);
    tick();
    check_eq("beq_bc", 32'(branch_control), 32'd1);
    check_eq("beq_br_pc", 32'(br_pc), 32'd9);
    check_eq("beq_ex_pc", 32'(ex_pc), 32'd5);
    present(mk(6'b000000, 5'd0, 5'd0, 16'd0), 11'd7);
    tick();
    branch_alu = 1'b0;
    check_eq("sq_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("sq_bc", 32'(branch_control), 32'd0);
    check_eq("sq_cnt", 32'(squash_cnt), 32'd1);
    present(mk(6'b000000, 5'd0, 5'd0, 16'd0), 11'd9);
    tick();
    check_eq("sq_idvalid0", 32'(ex_valid), 32'd0);
    present(mk(6'b000000, 5'd0, 5'd0, 16'd0), 11'd10);
    tick();
    check_eq("tgt_ex_valid", 32'(ex_valid), 32'd1);
    check_eq("tgt_ex_pc", 32'(ex_pc), 32'd9);

    // not-taken BNE at pc 5 imm 3
    present(mk(6'b000101, 5'd1, 5'd2, 16'd3), 11'd5);
    tick();
    present(mk(6'b000000, 5'd0, 5'd0, 16'd0), 11'd6);
    tick();
    check_eq("bne_bc", 32'(branch_control), 32'd1);
    check_eq("bne_br_pc", 32'(br_pc), 32'd9);
    present(mk(6'b000000, 5'd0, 5'd0, 16'd0), 11'd7);
    tick();
    check_eq("bne_ex_valid", 32'(ex_valid), 32'd1);
    check_eq("bne_ex_pc", 32'(ex_pc), 32'd6);
    check_eq("bne_squash", 32'(squash_cnt), 32'd1);

    // load-use: LW rt=4 then ADD rs=4
    present(mk(6'b100011, 5'd0, 5'd4, 16'd0), 11'd10);
    tick();
    present(mk(6'b000000, 5'd4, 5'd5, 16'h0020), 11'd11);
    tick();
    check_eq("lw_is_load", 32'(ex_is_load), 32'd1);
    check_eq("lu_stall", 32'(stall), 32'd1);
    present(mk(6'b000000, 5'd0, 5'd0, 16'd0), 11'd12);
    tick();
    check_eq("lu_bubble", 32'(ex_valid), 32'd0);
    check_eq("lu_stall_clr", 32'(stall), 32'd0);
    check_eq("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    tick();
    check_eq("lu_add_valid", 32'(ex_valid), 32'd1);
    check_eq("lu_add_pc", 32'(ex_pc), 32'd11);
    check_eq("lu_add_inst", ex_inst, mk(6'b000000, 5'd4, 5'd5, 16'h0020));

    // LW rt=0 then consumer of r0: no stall
    present(mk(6'b100011, 5'd0, 5'd0, 16'd0), 11'd20);
    tick();
    present(mk(6'b000000, 5'd0, 5'd0, 16'h0020), 11'd21);
    tick();
    check_eq("lw0_is_load", 32'(ex_is_load), 32'd1);
    check_eq("lw0_no_stall", 32'(stall), 32'd0);

    // J and BEQ at 0x7FF with wrap, then fall-through target
    present(mk(6'b000010, 5'd0, 5'd0, 16'h0123), 11'h7FF);
    tick();
    present(mk(6'b000100, 5'd0, 5'd0, 16'd0), 11'h7FF);
    tick();
    check_eq("j_bc", 32'(branch_control), 32'd1);
    check_eq("j_br_pc", 32'(br_pc), 32'h123);
    present(mk(6'b000000, 5'd0, 5'd0, 16'd0), 11'h100);
    tick();
    check_eq("beq_wrap_bc", 32'(branch_control), 32'd1);
    check_eq("beq_wrap_br_pc", 32'(br_pc), 32'h000);
    tick();
    check_eq("r_fall_bc", 32'(branch_control), 32'd0);
    check_eq("r_fall_br_pc", 32'(br_pc), 32'h101);

    // saturate squash counter: each taken branch takes three cycles
    branch_alu = 1'b1;
    present(mk(6'b000100, 5'd0, 5'd0, 16'd1), 11'd40);
    for (int i = 0; i < 960; i++) tick();
    check_eq("squash_sat", 32'(squash_cnt), 32'd255);
    branch_alu = 1'b0;

    // reset asserted mid-stall
    present(mk(6'b100011, 5'd0, 5'd4, 16'd0), 11'd30);
    tick();
    present(mk(6'b000000, 5'd4, 5'd5, 16'h0020), 11'd31);
    tick();
    check_eq("rs_stall", 32'(stall), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("ar_stall", 32'(stall), 32'd0);
    check_eq("ar_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("ar_bc", 32'(branch_control), 32'd0);
    check_eq("ar_br_pc", 32'(br_pc), 32'd0);
    check_eq("ar_ex_pc", 32'(ex_pc), 32'd0);
    check_eq("ar_ex_inst", ex_inst, 32'd0);
    check_eq("ar_is_load", 32'(ex_is_load), 32'd0);
    check_eq("ar_squash", 32'(squash_cnt), 32'd0);
    check_eq("ar_stall_cnt", 32'(stall_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
